// File: rtl/ym3438_pkg.sv
// Shared constants and helpers for the YM3438 operator phase-to-log-sine path.
// Latency: n/a (package only).
// Backpressure: n/a; the pipeline is paced solely by the c1/c2 enables.
package ym3438_pkg;

  localparam int SLOT_COUNT = 24;
  localparam int PHASE_W    = 10;
  localparam int LOGSIN_W   = 12;
  localparam int QUARTER_W  = 8;
  localparam int SLOT_W     = 5;
  localparam int PIPE_DEPTH = 3;

  localparam logic [LOGSIN_W-1:0] MUTE_ATTEN = 12'hFFF;
  localparam logic [SLOT_W-1:0]   SLOT_LAST  = SLOT_W'(SLOT_COUNT - 1);

  // Next slot index, wrapping after the last operator slot
  function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] s);
    return (s == SLOT_LAST) ? '0 : s + 5'd1;
  endfunction

  // Fold a 10-bit phase onto the rising quarter of the sine table
  function automatic logic [QUARTER_W-1:0] fold_quarter(input logic [PHASE_W-1:0] ph);
    return ph[8] ? ~ph[7:0] : ph[7:0];
  endfunction

endpackage

// File: rtl/ym3438_logsin_rom.sv
// Quarter-wave log-sine table: round(-log2(sin((2i+1)*pi/1024))*256), 4.8 fixed point.
// Latency: purely combinational.
// Backpressure: none.
module ym3438_logsin_rom
  import ym3438_pkg::*;
(
  input  logic [QUARTER_W-1:0] addr,
  output logic [LOGSIN_W-1:0]  data
);

  // Table lookup, eight entries per line
  always_comb begin
    data = '0;
    case (addr)
      8'h00: data = 12'h859; 8'h01: data = 12'h6c3; 8'h02: data = 12'h607; 8'h03: data = 12'h58b; 8'h04: data = 12'h52e; 8'h05: data = 12'h4e4; 8'h06: data = 12'h4a6; 8'h07: data = 12'h471;
      8'h08: data = 12'h443; 8'h09: data = 12'h41a; 8'h0a: data = 12'h3f5; 8'h0b: data = 12'h3d3; 8'h0c: data = 12'h3b5; 8'h0d: data = 12'h398; 8'h0e: data = 12'h37e; 8'h0f: data = 12'h365;
      8'h10: data = 12'h34e; 8'h11: data = 12'h339; 8'h12: data = 12'h324; 8'h13: data = 12'h311; 8'h14: data = 12'h2ff; 8'h15: data = 12'h2ed; 8'h16: data = 12'h2dc; 8'h17: data = 12'h2cd;
      8'h18: data = 12'h2bd; 8'h19: data = 12'h2af; 8'h1a: data = 12'h2a0; 8'h1b: data = 12'h293; 8'h1c: data = 12'h286; 8'h1d: data = 12'h279; 8'h1e: data = 12'h26d; 8'h1f: data = 12'h261;
      8'h20: data = 12'h256; 8'h21: data = 12'h24b; 8'h22: data = 12'h240; 8'h23: data = 12'h236; 8'h24: data = 12'h22c; 8'h25: data = 12'h222; 8'h26: data = 12'h218; 8'h27: data = 12'h20f;
      8'h28: data = 12'h206; 8'h29: data = 12'h1fd; 8'h2a: data = 12'h1f5; 8'h2b: data = 12'h1ec; 8'h2c: data = 12'h1e4; 8'h2d: data = 12'h1dc; 8'h2e: data = 12'h1d4; 8'h2f: data = 12'h1cd;
      8'h30: data = 12'h1c5; 8'h31: data = 12'h1be; 8'h32: data = 12'h1b7; 8'h33: data = 12'h1b0; 8'h34: data = 12'h1a9; 8'h35: data = 12'h1a2; 8'h36: data = 12'h19b; 8'h37: data = 12'h195;
      8'h38: data = 12'h18f; 8'h39: data = 12'h188; 8'h3a: data = 12'h182; 8'h3b: data = 12'h17c; 8'h3c: data = 12'h177; 8'h3d: data = 12'h171; 8'h3e: data = 12'h16b; 8'h3f: data = 12'h166;
      8'h40: data = 12'h160; 8'h41: data = 12'h15b; 8'h42: data = 12'h155; 8'h43: data = 12'h150; 8'h44: data = 12'h14b; 8'h45: data = 12'h146; 8'h46: data = 12'h141; 8'h47: data = 12'h13c;
      8'h48: data = 12'h137; 8'h49: data = 12'h133; 8'h4a: data = 12'h12e; 8'h4b: data = 12'h129; 8'h4c: data = 12'h125; 8'h4d: data = 12'h121; 8'h4e: data = 12'h11c; 8'h4f: data = 12'h118;
      8'h50: data = 12'h114; 8'h51: data = 12'h10f; 8'h52: data = 12'h10b; 8'h53: data = 12'h107; 8'h54: data = 12'h103; 8'h55: data = 12'h0ff; 8'h56: data = 12'h0fb; 8'h57: data = 12'h0f8;
      8'h58: data = 12'h0f4; 8'h59: data = 12'h0f0; 8'h5a: data = 12'h0ec; 8'h5b: data = 12'h0e9; 8'h5c: data = 12'h0e5; 8'h5d: data = 12'h0e2; 8'h5e: data = 12'h0de; 8'h5f: data = 12'h0db;
      8'h60: data = 12'h0d7; 8'h61: data = 12'h0d4; 8'h62: data = 12'h0d1; 8'h63: data = 12'h0cd; 8'h64: data = 12'h0ca; 8'h65: data = 12'h0c7; 8'h66: data = 12'h0c4; 8'h67: data = 12'h0c1;
      8'h68: data = 12'h0be; 8'h69: data = 12'h0bb; 8'h6a: data = 12'h0b8; 8'h6b: data = 12'h0b5; 8'h6c: data = 12'h0b2; 8'h6d: data = 12'h0af; 8'h6e: data = 12'h0ac; 8'h6f: data = 12'h0a9;
      8'h70: data = 12'h0a7; 8'h71: data = 12'h0a4; 8'h72: data = 12'h0a1; 8'h73: data = 12'h09f; 8'h74: data = 12'h09c; 8'h75: data = 12'h099; 8'h76: data = 12'h097; 8'h77: data = 12'h094;
      8'h78: data = 12'h092; 8'h79: data = 12'h08f; 8'h7a: data = 12'h08d; 8'h7b: data = 12'h08a; 8'h7c: data = 12'h088; 8'h7d: data = 12'h086; 8'h7e: data = 12'h083; 8'h7f: data = 12'h081;
      8'h80: data = 12'h07f; 8'h81: data = 12'h07d; 8'h82: data = 12'h07a; 8'h83: data = 12'h078; 8'h84: data = 12'h076; 8'h85: data = 12'h074; 8'h86: data = 12'h072; 8'h87: data = 12'h070;
      8'h88: data = 12'h06e; 8'h89: data = 12'h06c; 8'h8a: data = 12'h06a; 8'h8b: data = 12'h068; 8'h8c: data = 12'h066; 8'h8d: data = 12'h064; 8'h8e: data = 12'h062; 8'h8f: data = 12'h060;
      8'h90: data = 12'h05e; 8'h91: data = 12'h05c; 8'h92: data = 12'h05b; 8'h93: data = 12'h059; 8'h94: data = 12'h057; 8'h95: data = 12'h055; 8'h96: data = 12'h053; 8'h97: data = 12'h052;
      8'h98: data = 12'h050; 8'h99: data = 12'h04e; 8'h9a: data = 12'h04d; 8'h9b: data = 12'h04b; 8'h9c: data = 12'h04a; 8'h9d: data = 12'h048; 8'h9e: data = 12'h046; 8'h9f: data = 12'h045;
      8'ha0: data = 12'h043; 8'ha1: data = 12'h042; 8'ha2: data = 12'h040; 8'ha3: data = 12'h03f; 8'ha4: data = 12'h03e; 8'ha5: data = 12'h03c; 8'ha6: data = 12'h03b; 8'ha7: data = 12'h039;
      8'ha8: data = 12'h038; 8'ha9: data = 12'h037; 8'haa: data = 12'h035; 8'hab: data = 12'h034; 8'hac: data = 12'h033; 8'had: data = 12'h031; 8'hae: data = 12'h030; 8'haf: data = 12'h02f;
      8'hb0: data = 12'h02e; 8'hb1: data = 12'h02d; 8'hb2: data = 12'h02b; 8'hb3: data = 12'h02a; 8'hb4: data = 12'h029; 8'hb5: data = 12'h028; 8'hb6: data = 12'h027; 8'hb7: data = 12'h026;
      8'hb8: data = 12'h025; 8'hb9: data = 12'h024; 8'hba: data = 12'h023; 8'hbb: data = 12'h022; 8'hbc: data = 12'h021; 8'hbd: data = 12'h020; 8'hbe: data = 12'h01f; 8'hbf: data = 12'h01e;
      8'hc0: data = 12'h01d; 8'hc1: data = 12'h01c; 8'hc2: data = 12'h01b; 8'hc3: data = 12'h01a; 8'hc4: data = 12'h019; 8'hc5: data = 12'h018; 8'hc6: data = 12'h017; 8'hc7: data = 12'h017;
      8'hc8: data = 12'h016; 8'hc9: data = 12'h015; 8'hca: data = 12'h014; 8'hcb: data = 12'h014; 8'hcc: data = 12'h013; 8'hcd: data = 12'h012; 8'hce: data = 12'h011; 8'hcf: data = 12'h011;
      8'hd0: data = 12'h010; 8'hd1: data = 12'h00f; 8'hd2: data = 12'h00f; 8'hd3: data = 12'h00e; 8'hd4: data = 12'h00d; 8'hd5: data = 12'h00d; 8'hd6: data = 12'h00c; 8'hd7: data = 12'h00c;
      8'hd8: data = 12'h00b; 8'hd9: data = 12'h00a; 8'hda: data = 12'h00a; 8'hdb: data = 12'h009; 8'hdc: data = 12'h009; 8'hdd: data = 12'h008; 8'hde: data = 12'h008; 8'hdf: data = 12'h007;
      8'he0: data = 12'h007; 8'he1: data = 12'h007; 8'he2: data = 12'h006; 8'he3: data = 12'h006; 8'he4: data = 12'h005; 8'he5: data = 12'h005; 8'he6: data = 12'h005; 8'he7: data = 12'h004;
      8'he8: data = 12'h004; 8'he9: data = 12'h004; 8'hea: data = 12'h003; 8'heb: data = 12'h003; 8'hec: data = 12'h003; 8'hed: data = 12'h002; 8'hee: data = 12'h002; 8'hef: data = 12'h002;
      8'hf0: data = 12'h002; 8'hf1: data = 12'h001; 8'hf2: data = 12'h001; 8'hf3: data = 12'h001; 8'hf4: data = 12'h001; 8'hf5: data = 12'h001; 8'hf6: data = 12'h001; 8'hf7: data = 12'h001;
      8'hf8: data = 12'h000; 8'hf9: data = 12'h000; 8'hfa: data = 12'h000; 8'hfb: data = 12'h000; 8'hfc: data = 12'h000; 8'hfd: data = 12'h000; 8'hfe: data = 12'h000; 8'hff: data = 12'h000;
    endcase
  end

endmodule

// File: rtl/ym3438_op_phase.sv
// Operator phase path: (pg + mod) mod 1024 -> quarter fold -> log-sine ROM, with slot tagging.
// Latency: exactly 3 slot ticks (c2 edges) from the c1 input sample to logsin/sign/slot outputs.
// Backpressure: none; c1 samples and c2 advances unconditionally, other edges hold state.
module ym3438_op_phase
  import ym3438_pkg::*;
(
  input  logic                MCLK,
  input  logic                IC,
  input  logic                c1,
  input  logic                c2,
  input  logic [PHASE_W-1:0]  pg_in,
  input  logic [PHASE_W-1:0]  mod_in,
  input  logic                slot_sync,
  input  logic                mute,
  output logic [LOGSIN_W-1:0] logsin_out,
  output logic                sign_out,
  output logic [SLOT_W-1:0]   slot_out,
  output logic                out_valid
);

  // Stage 0: sampled inputs; the slot counter lives here and tags the sample as it leaves
  logic [PHASE_W-1:0]   s0_pg_q, s0_pg_d;
  logic [PHASE_W-1:0]   s0_mod_q, s0_mod_d;
  logic                 s0_mute_q, s0_mute_d;
  logic [SLOT_W-1:0]    s0_slot_q, s0_slot_d;
  // Stage 1: wrapped phase sum
  logic [PHASE_W-1:0]   s1_sum_q, s1_sum_d;
  logic                 s1_mute_q, s1_mute_d;
  logic [SLOT_W-1:0]    s1_slot_q, s1_slot_d;
  // Stage 2: folded quarter address and sign
  logic [QUARTER_W-1:0] s2_quarter_q, s2_quarter_d;
  logic                 s2_sign_q, s2_sign_d;
  logic                 s2_mute_q, s2_mute_d;
  logic [SLOT_W-1:0]    s2_slot_q, s2_slot_d;
  // Stage 3: registered outputs
  logic [LOGSIN_W-1:0]  s3_logsin_q, s3_logsin_d;
  logic                 s3_sign_q, s3_sign_d;
  logic [SLOT_W-1:0]    s3_slot_q, s3_slot_d;
  logic [PIPE_DEPTH-1:0] vld_q, vld_d;

  logic [LOGSIN_W-1:0]  rom_dat;

  ym3438_logsin_rom u_rom (
    .addr (s2_quarter_q),
    .data (rom_dat)
  );

  // Input sample on c1; slot counter advances per tick, a sampled slot_sync pins it to 0
  always_comb begin
    s0_pg_d   = s0_pg_q;
    s0_mod_d  = s0_mod_q;
    s0_mute_d = s0_mute_q;
    s0_slot_d = s0_slot_q;
    if (c1) begin
      s0_pg_d   = pg_in;
      s0_mod_d  = mod_in;
      s0_mute_d = mute;
    end
    if (c1 && slot_sync) begin
      s0_slot_d = '0;
    end else if (c2) begin
      s0_slot_d = slot_next(s0_slot_q);
    end
  end

  // Stages 1 and 2 advance on the tick; sum is kept at 10 bits so the carry is dropped
  always_comb begin
    s1_sum_d     = s1_sum_q;
    s1_mute_d    = s1_mute_q;
    s1_slot_d    = s1_slot_q;
    s2_quarter_d = s2_quarter_q;
    s2_sign_d    = s2_sign_q;
    s2_mute_d    = s2_mute_q;
    s2_slot_d    = s2_slot_q;
    if (c2) begin
      s1_sum_d     = s0_pg_q + s0_mod_q;
      s1_mute_d    = s0_mute_q;
      s1_slot_d    = s0_slot_q;
      s2_quarter_d = fold_quarter(s1_sum_q);
      s2_sign_d    = s1_sum_q[9];
      s2_mute_d    = s1_mute_q;
      s2_slot_d    = s1_slot_q;
    end
  end

  // Output stage: ROM lookup or forced maximum attenuation; valid fills after three ticks
  always_comb begin
    s3_logsin_d = s3_logsin_q;
    s3_sign_d   = s3_sign_q;
    s3_slot_d   = s3_slot_q;
    vld_d       = vld_q;
    if (c2) begin
      s3_logsin_d = s2_mute_q ? MUTE_ATTEN : rom_dat;
      s3_sign_d   = s2_sign_q;
      s3_slot_d   = s2_slot_q;
      vld_d       = {vld_q[PIPE_DEPTH-2:0], 1'b1};
    end
  end

  // All state: cleared asynchronously by IC, otherwise updated from the next-state logic
  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      s0_pg_q      <= '0;
      s0_mod_q     <= '0;
      s0_mute_q    <= 1'b0;
      s0_slot_q    <= '0;
      s1_sum_q     <= '0;
      s1_mute_q    <= 1'b0;
      s1_slot_q    <= '0;
      s2_quarter_q <= '0;
      s2_sign_q    <= 1'b0;
      s2_mute_q    <= 1'b0;
      s2_slot_q    <= '0;
      s3_logsin_q  <= MUTE_ATTEN;
      s3_sign_q    <= 1'b0;
      s3_slot_q    <= '0;
      vld_q        <= '0;
    end else begin
      s0_pg_q      <= s0_pg_d;
      s0_mod_q     <= s0_mod_d;
      s0_mute_q    <= s0_mute_d;
      s0_slot_q    <= s0_slot_d;
      s1_sum_q     <= s1_sum_d;
      s1_mute_q    <= s1_mute_d;
      s1_slot_q    <= s1_slot_d;
      s2_quarter_q <= s2_quarter_d;
      s2_sign_q    <= s2_sign_d;
      s2_mute_q    <= s2_mute_d;
      s2_slot_q    <= s2_slot_d;
      s3_logsin_q  <= s3_logsin_d;
      s3_sign_q    <= s3_sign_d;
      s3_slot_q    <= s3_slot_d;
      vld_q        <= vld_d;
    end
  end

  assign logsin_out = s3_logsin_q;
  assign sign_out   = s3_sign_q;
  assign slot_out   = s3_slot_q;
  assign out_valid  = vld_q[PIPE_DEPTH-1];

endmodule

// File: doc/ym3438_op_phase.md
YM3438_OP_PHASE -- requirements
Module: ym3438_op_phase

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked by MCLK and cleared immediately by IC low, independent of MCLK.
REQ-002 SHALL use slot tick = MCLK rising edge with c2=1; a MCLK rising edge with c1=1 samples the inputs; all other edges hold state.
REQ-003 Ports (name  direction  width  meaning):
REQ-004 MCLK  in  1  master clock.
REQ-005 IC  in  1  asynchronous reset, active low.
REQ-006 c1  in  1  phase-1 enable (input sample).
REQ-007 c2  in  1  phase-2 enable (pipeline advance).
REQ-008 pg_in  in  10  phase from the phase generator, upper 10 bits of the 20-bit accumulator.
REQ-009 mod_in  in  10  modulation/feedback phase offset, unsigned modulo 1024.
REQ-010 slot_sync  in  1  marks slot 0 at the input sample.
REQ-011 mute  in  1  forces the maximum-attenuation output for the sampled slot.
REQ-012 logsin_out  out  12  log-sine attenuation, 4.8 fixed point.
REQ-013 sign_out  out  1  waveform sign, 1 = negative half.
REQ-014 slot_out  out  5  slot index aligned with logsin_out, 0..23.
REQ-015 out_valid  out  1  high once the pipeline holds post-reset data.

Function
REQ-016 Stage 0 (c1 sample) SHALL latch pg_in, mod_in, mute and slot_sync.
REQ-017 Stage 1 (tick) SHALL compute sum = (pg + mod) mod 1024; there is no carry out and 0x3FF+0x001 = 0x000.
REQ-018 Stage 2 (tick) SHALL compute quarter = sum[8] ? ~sum[7:0] : sum[7:0] and sign = sum[9].
REQ-019 Stage 3 (tick) SHALL drive logsin_out = ROM[quarter], and SHALL drive 0xFFF instead when mute was sampled with that slot.
REQ-020 ROM[i] SHALL equal round(-log2(sin((2i+1)·π/1024))·256), giving 256 entries x 12 bits with ROM[0]=0x859 and ROM[255]=0x000.
REQ-021 sign_out, slot_out and mute SHALL travel in lockstep with their data; total latency from c1 sample to output SHALL be exactly 3 slot ticks.
REQ-022 The slot counter SHALL increment 0..23 on each tick and wrap 23->0.
REQ-023 slot_sync sampled high SHALL force the counter for that sample to 0; slot_sync takes precedence over the wrap and over the increment.
REQ-024 slot_sync arriving at a non-23 count SHALL resynchronise the counter without any output glitch other than the slot_out jump.
REQ-025 Simultaneous c1 and c2 on the same edge SHALL sample the new input and advance the pipeline, with the freshly sampled value entering stage 1 on the next tick only.
REQ-026 out_valid SHALL rise on the 3rd tick after IC deasserts and stay high until the next reset.

Reset
REQ-027 While IC is low: logsin_out=0xFFF, sign_out=0, slot_out=0, out_valid=0, and all pipeline registers and the counter are 0.
REQ-028 Reset asserted mid-operation SHALL discard in-flight slots; no partial result appears after release.
REQ-029 Reset SHALL not depend on c1/c2 activity.

Structure
REQ-030 Shared package ym3438_pkg SHALL hold SLOT_COUNT=24, PHASE_W=10, LOGSIN_W=12, MUTE_ATTEN=12'hFFF and the pipeline depth 3.
REQ-031 The ROM SHALL be a sub-module ym3438_logsin_rom: combinational, 8-bit address in, 12-bit data out, generated from REQ-020.
REQ-032 All arithmetic SHALL be unsigned at declared widths, with no implicit extension beyond 10 bits before the modulo.

Verification
REQ-033 pg=0x000, mod=0x000 -> after 3 ticks logsin_out=0x859, sign_out=0.
REQ-034 pg=0x100, mod=0x000 -> quarter=0xFF, logsin_out=0x000, sign_out=0; pg=0x300 -> logsin_out=0x000, sign_out=1.
REQ-035 pg=0x3FF, mod=0x001 -> sum wraps to 0x000, logsin_out=0x859, sign_out=0.
REQ-036 slot_sync pulsed, then 24 ticks -> slot_out runs 0..23 then 0, lagging the input by 3 ticks; slot_sync reasserted at count 10 -> next slot_out sequence restarts at 0.
REQ-037 mute=1 on one slot amid pg=0x000 traffic -> that slot alone outputs 0xFFF, and its neighbours output 0x859.
REQ-038 IC pulsed low mid-stream -> outputs go immediately to 0xFFF/0/0/0; after release out_valid returns on the 3rd tick, with no pre-reset data emitted.
